ram_arbiter: RTL and testbench

Two-port arbiter sharing the single-port data/instruction `ram` between the instruction-fetch port (I) and the load/store port (D) of the single-cycle core. It accepts at most one access per cycle and forwards it to the RAM. Read data returns exactly one cycle after grant, tagged to the owning port. Round-robin fairness prevents starvation, and a D-side lock supports atomic read-modify-write sequences.

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_rr_arb2.sv | 42 ++++
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings and limits for the I/D RAM arbiter.
package ram_arbiter_pkg;

    // Port ownership encodings (round-robin history and read tag)
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Maximum number of consecutive D grants held under d_lock
    localparam int LOCK_MAX   = 4;
    localparam int LOCK_CNT_W = 3;

    // Byte write-mask width of the RAM
    localparam int WMASK_W = 4;

    // Arbiter FSM states
    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On a conflict the port that did not win
// most recently is granted; history resets to D so I wins the first tie.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    logic last_owner_q;
    logic last_owner_d;

    // Grant selection and next owner history
    always_comb begin
        gnt_i        = 1'b0;
        gnt_d        = 1'b0;
        last_owner_d = last_owner_q;
        if (en) begin
            if (req_i && req_d) begin
                if (last_owner_q == OWNER_D) gnt_i = 1'b1;
                else                         gnt_d = 1'b1;
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
        end
        if (gnt_i)      last_owner_d = OWNER_I;
        else if (gnt_d) last_owner_d = OWNER_D;
    end

    // Owner history register
    always_ff @(posedge clk) begin
        if (rst) last_owner_q <= OWNER_D;
        else     last_owner_q <= last_owner_d;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between instruction fetch (I) and load/store
// (D). One access per cycle, read data tagged back to its owner one cycle
// after grant, with a bounded D-side lock for read-modify-write sequences.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int N = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [31:0]        i_addr,
    output logic               i_gnt,
    output logic               i_rvalid,
    output logic [31:0]        i_rdata,
    input  logic               d_req,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    input  logic [WMASK_W-1:0] d_wmask,
    input  logic               d_lock,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [31:0]        d_rdata,
    output logic               d_err,
    output logic [31:0]        ram_address,
    output logic [31:0]        ram_data_in,
    output logic [WMASK_W-1:0] ram_wmask,
    input  logic [31:0]        ram_data_out
);

    logic [0:0]            state_q, state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  tag_vld_q, tag_vld_d;
    logic                  tag_owner_q, tag_owner_d;
    logic                  arb_en, arb_gnt_i, arb_gnt_d;

    // Round-robin only runs in ARB; LOCKED bypasses it and serves D alone.
    // D already holds last-owner history when LOCKED is entered.
    assign arb_en = !rst && (state_q == ST_ARB);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req_i (i_req),
        .req_d (d_req),
        .gnt_i (arb_gnt_i),
        .gnt_d (arb_gnt_d)
    );

    // Grants and RAM request mux; nothing is driven without a grant
    always_comb begin
        i_gnt       = arb_gnt_i;
        d_gnt       = arb_gnt_d || (!rst && (state_q == ST_LOCKED) && d_req);
        ram_address = 32'd0;
        ram_data_in = 32'd0;
        ram_wmask   = '0;
        if (d_gnt) begin
            ram_address = d_addr;
            ram_data_in = d_wdata;
            ram_wmask   = d_wmask;
        end else if (i_gnt) begin
            ram_address = i_addr;
        end
        // Out-of-range accesses still go to the RAM (it wraps); only flagged
        d_err = d_gnt && ((d_addr >> (N + 2)) != 32'd0);
    end

    // Lock FSM: a locked D grant holds the RAM for at most LOCK_MAX
    // consecutive grants, counting the grant that took the lock. Afterwards
    // ARB resumes with last owner D, so a waiting I wins next.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (d_gnt && d_lock) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = LOCK_CNT_W'(1);
                end
            end
            default: begin
                if (!d_req || !d_lock || (lock_cnt_q == LOCK_CNT_W'(LOCK_MAX - 1))) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                end
            end
        endcase
    end

    // Read tag: remember who owns the read issued this cycle
    always_comb begin
        tag_vld_d   = (i_gnt || d_gnt) && (ram_wmask == '0);
        tag_owner_d = d_gnt ? OWNER_D : OWNER_I;
    end

    // State, lock counter and tag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            lock_cnt_q  <= '0;
            tag_vld_q   <= 1'b0;
            tag_owner_q <= OWNER_I;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            tag_vld_q   <= tag_vld_d;
            tag_owner_q <= tag_owner_d;
        end
    end

    // Read return; rvalid is held low while reset is asserted
    always_comb begin
        i_rvalid = !rst && tag_vld_q && (tag_owner_q == OWNER_I);
        d_rvalid = !rst && tag_vld_q && (tag_owner_q == OWNER_D);
        i_rdata  = ram_data_out;
        d_rdata  = ram_data_out;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with a behavioural RAM that
// registers its read data one cycle, like the real block.
module tb_ram_arbiter;

    localparam int NW = 7;
    localparam logic [31:0] A = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_lock;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wmask;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata, ram_address, ram_data_in, ram_data_out;
    logic [3:0]  ram_wmask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.N(NW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_wmask(ram_wmask), .ram_data_out(ram_data_out)
    );

    // RAM model: word i holds A+i, except word 16 (0x40) = 0x11223344
    logic [31:0] mem [1<<NW];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << NW); i++)
                mem[i] <= (i == 16) ? 32'h1122_3344 : A + 32'(i);
            ram_data_out <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wmask[b]) mem[ram_address[NW+1:2]][8*b +: 8] <= ram_data_in[8*b +: 8];
            ram_data_out <= mem[ram_address[NW+1:2]];
        end
    end

    typedef struct {
        logic        rst, ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr, wdata;
        logic [3:0]  wmask;
        logic        lock;
        logic        eig, edg, eiv, edv;
        logic [31:0] erd;
        logic        eerr;
        logic [31:0] eaddr, edin;
        logic [3:0]  ewm;
    } vec_t;

    function automatic vec_t v(
        input logic rs, ir, input logic [31:0] ia,
        input logic dr, input logic [31:0] da, wd, input logic [3:0] wm, input logic lk,
        input logic eig, edg, eiv, edv, input logic [31:0] erd, input logic eerr,
        input logic [31:0] ea, edi, input logic [3:0] ewm);
        vec_t t;
        t.rst = rs; t.ireq = ir; t.iaddr = ia;
        t.dreq = dr; t.daddr = da; t.wdata = wd; t.wmask = wm; t.lock = lk;
        t.eig = eig; t.edg = edg; t.eiv = eiv; t.edv = edv; t.erd = erd; t.eerr = eerr;
        t.eaddr = ea; t.edin = edi; t.ewm = ewm;
        return t;
    endfunction

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h want %h", tag, nm, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, check on the falling edge
    task automatic run(input vec_t t, input string tag);
        @(posedge clk);
        #1;
        rst = t.rst; i_req = t.ireq; i_addr = t.iaddr;
        d_req = t.dreq; d_addr = t.daddr; d_wdata = t.wdata; d_wmask = t.wmask; d_lock = t.lock;
        @(negedge clk);
        chk(tag, "i_gnt",    32'(i_gnt),     32'(t.eig));
        chk(tag, "d_gnt",    32'(d_gnt),     32'(t.edg));
        chk(tag, "i_rvalid", 32'(i_rvalid),  32'(t.eiv));
        chk(tag, "d_rvalid", 32'(d_rvalid),  32'(t.edv));
        chk(tag, "d_err",    32'(d_err),     32'(t.eerr));
        chk(tag, "ram_addr", ram_address,    t.eaddr);
        chk(tag, "ram_din",  ram_data_in,    t.edin);
        chk(tag, "ram_wm",   32'(ram_wmask), 32'(t.ewm));
        if (t.eiv) chk(tag, "i_rdata", i_rdata, t.erd);
        if (t.edv) chk(tag, "d_rdata", d_rdata, t.erd);
    endtask

    vec_t tbl [17];

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
        d_wdata = '0; d_wmask = '0; d_lock = 1'b0;

        //           rst ir ia      dr da       wdata         wm  lk  ig dg iv dv rdata         err addr     din           wm
        tbl[0]  = v(1, 1, 'h10,  1, 'h1000, 0,            0,  0,  0, 0, 0, 0, 0,            0, 0,       0,            0);
        tbl[1]  = v(0, 1, 'h10,  1, 'h20,   0,            0,  0,  1, 0, 0, 0, 0,            0, 'h10,    0,            0);
        tbl[2]  = v(0, 0, 0,     1, 'h20,   0,            0,  0,  0, 1, 1, 0, A+4,          0, 'h20,    0,            0);
        tbl[3]  = v(0, 1, 'h0,   0, 0,      0,            0,  0,  1, 0, 0, 1, A+8,          0, 'h0,     0,            0);
        tbl[4]  = v(0, 1, 'h4,   0, 0,      0,            0,  0,  1, 0, 1, 0, A+0,          0, 'h4,     0,            0);
        tbl[5]  = v(0, 1, 'h8,   0, 0,      0,            0,  0,  1, 0, 1, 0, A+1,          0, 'h8,     0,            0);
        tbl[6]  = v(0, 0, 0,     1, 'h40,   32'hDEADBEEF, 3,  0,  0, 1, 1, 0, A+2,          0, 'h40,    32'hDEADBEEF, 3);
        tbl[7]  = v(0, 0, 0,     1, 'h40,   0,            0,  0,  0, 1, 0, 0, 0,            0, 'h40,    0,            0);
        tbl[8]  = v(0, 0, 0,     0, 0,      0,            0,  0,  0, 0, 0, 1, 32'h1122BEEF, 0, 0,       0,            0);
        tbl[9]  = v(0, 1, 'hC,   1, 'h24,   0,            0,  0,  1, 0, 0, 0, 0,            0, 'hC,     0,            0);
        tbl[10] = v(0, 0, 0,     1, 'h24,   0,            0,  0,  0, 1, 1, 0, A+3,          0, 'h24,    0,            0);
        tbl[11] = v(0, 0, 0,     1, 'h1000, 0,            0,  0,  0, 1, 0, 1, A+9,          1, 'h1000,  0,            0);
        tbl[12] = v(0, 0, 0,     0, 0,      0,            0,  0,  0, 0, 0, 1, A+0,          0, 0,       0,            0);
        tbl[13] = v(0, 1, 'h8,   1, 'h44,   'h55,         15, 0,  1, 0, 0, 0, 0,            0, 'h8,     0,            0);
        tbl[14] = v(0, 0, 0,     1, 'h44,   'h55,         15, 0,  0, 1, 1, 0, A+2,          0, 'h44,    'h55,         15);
        tbl[15] = v(0, 1, 'h44,  0, 0,      0,            0,  0,  1, 0, 0, 0, 0,            0, 'h44,    0,            0);
        tbl[16] = v(0, 0, 0,     0, 0,      0,            0,  0,  0, 0, 1, 0, 'h55,         0, 0,       0,            0);

        repeat (2) @(posedge clk);

        for (int k = 0; k < 17; k++) run(tbl[k], $sformatf("v%0d", k));

        // Lock: D wins the tie (I won last), holds 4 grants, then I gets in
        run(v(0, 1, 0,   1, 'h28, 0,    0,  1,  0, 1, 0, 0, 0,    0, 'h28, 0,    0),  "lk1");
        run(v(0, 1, 0,   1, 'h28, 'h77, 15, 1,  0, 1, 0, 1, A+10, 0, 'h28, 'h77, 15), "lk2");
        run(v(0, 1, 0,   1, 'h2C, 0,    0,  1,  0, 1, 0, 0, 0,    0, 'h2C, 0,    0),  "lk3");
        run(v(0, 1, 0,   1, 'h2C, 0,    0,  1,  0, 1, 0, 1, A+11, 0, 'h2C, 0,    0),  "lk4");
        run(v(0, 1, 0,   1, 'h30, 0,    0,  1,  1, 0, 0, 1, A+11, 0, 0,    0,    0),  "lk5");
        run(v(0, 0, 0,   1, 'h30, 0,    0,  1,  0, 1, 1, 0, A+0,  0, 'h30, 0,    0),  "lk6");
        // d_req drops while locked: I still stalled this cycle, ARB next
        run(v(0, 1, 'h4, 0, 0,    0,    0,  0,  0, 0, 0, 1, A+12, 0, 0,    0,    0),  "lk7");
        run(v(0, 1, 'h4, 0, 0,    0,    0,  0,  1, 0, 0, 0, 0,    0, 'h4,  0,    0),  "lk8");
        run(v(0, 0, 0,   0, 0,    0,    0,  0,  0, 0, 1, 0, A+1,  0, 0,    0,    0),  "lk9");

        // Reset with a locked D read in flight: no rvalid, lock dropped
        run(v(0, 0, 0,   1, 'h34, 0,    0,  1,  0, 1, 0, 0, 0,    0, 'h34, 0,    0),  "rs1");
        run(v(1, 1, 0,   1, 0,    0,    0,  1,  0, 0, 0, 0, 0,    0, 0,    0,    0),  "rs2");
        run(v(0, 0, 0,   0, 0,    0,    0,  0,  0, 0, 0, 0, 0,    0, 0,    0,    0),  "rs3");
        run(v(0, 1, 0,   0, 0,    0,    0,  0,  1, 0, 0, 0, 0,    0, 0,    0,    0),  "rs4");
        run(v(0, 0, 0,   0, 0,    0,    0,  0,  0, 0, 1, 0, A+0,  0, 0,    0,    0),  "rs5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
